// File: rtl/imm_decode_stage.sv
// Registered RV immediate decoder with a two-entry (output + skid) ready/valid buffer.
// Each entry carries the raw instruction, its extended immediate and a 3-bit format code.
module imm_decode_stage #(
    parameter int XLEN       = 32,
    parameter int ENABLE_CSR = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_Z   = 3'd6;
    localparam logic [2:0] FMT_ILL = 3'd7;

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;

    logic            out_valid_q;
    logic [31:0]     out_instr_q;
    logic [XLEN-1:0] out_imm_q;
    logic [2:0]      out_fmt_q;
    logic            skid_valid_q;
    logic [31:0]     skid_instr_q;
    logic [XLEN-1:0] skid_imm_q;
    logic [2:0]      skid_fmt_q;
    logic            in_ready_q;

    logic accept, drain, out_free, skid_valid_next;

    // Sign bit is folded into the replication so every layout works for XLEN 32 and 64.
    assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
    assign imm_j = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    assign imm_z = {{(XLEN-5){1'b0}}, in_instr[19:15]};

    always_comb begin
        dec_fmt = FMT_ILL;
        dec_imm = '0;
        case (in_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: begin
                dec_fmt = FMT_I;
                dec_imm = imm_i;
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                dec_imm = imm_s;
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                dec_imm = imm_b;
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FMT_U;
                dec_imm = imm_u;
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                dec_imm = imm_j;
            end
            7'b0110011: begin
                dec_fmt = FMT_R;
            end
            7'b1110011: begin
                if (ENABLE_CSR != 0 && in_instr[14]) begin
                    dec_fmt = FMT_Z;
                    dec_imm = imm_z;
                end else begin
                    dec_fmt = FMT_I;
                    dec_imm = imm_i;
                end
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    dec_fmt = FMT_I;
                    dec_imm = imm_i;
                end
            end
            7'b0111011: begin
                if (XLEN == 64) begin
                    dec_fmt = FMT_R;
                end
            end
            default: begin
                dec_fmt = FMT_ILL;
                dec_imm = '0;
            end
        endcase
    end

    assign accept   = in_valid && in_ready_q;
    assign drain    = out_valid_q && out_ready;
    assign out_free = !out_valid_q || drain;

    always_comb begin
        skid_valid_next = skid_valid_q;
        if (out_free) begin
            skid_valid_next = skid_valid_q && accept;
        end else if (accept) begin
            skid_valid_next = 1'b1;
        end
    end

    // A skid entry always moves up before a new word; new words fill whichever slot is free in order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_instr_q  <= '0;
            out_imm_q    <= '0;
            out_fmt_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_imm_q   <= '0;
            skid_fmt_q   <= '0;
            in_ready_q   <= 1'b0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            if (out_free) begin
                if (skid_valid_q) begin
                    out_valid_q <= 1'b1;
                    out_instr_q <= skid_instr_q;
                    out_imm_q   <= skid_imm_q;
                    out_fmt_q   <= skid_fmt_q;
                    if (accept) begin
                        skid_instr_q <= in_instr;
                        skid_imm_q   <= dec_imm;
                        skid_fmt_q   <= dec_fmt;
                    end
                end else if (accept) begin
                    out_valid_q <= 1'b1;
                    out_instr_q <= in_instr;
                    out_imm_q   <= dec_imm;
                    out_fmt_q   <= dec_fmt;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end else if (accept) begin
                skid_instr_q <= in_instr;
                skid_imm_q   <= dec_imm;
                skid_fmt_q   <= dec_fmt;
            end
            skid_valid_q <= skid_valid_next;
            in_ready_q   <= !skid_valid_next;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_imm   = out_imm_q;
    assign out_fmt   = out_fmt_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: three instances (RV32, RV64, RV32 without CSR zimm)
// share one input stream; handshake scenarios are checked on the RV32 instance.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic        out_ready = 1'b0;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_instr;
    logic [31:0] a_out_imm;
    logic [2:0]  a_out_fmt;

    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_instr;
    logic [63:0] b_out_imm;
    logic [2:0]  b_out_fmt;

    logic        c_in_ready, c_out_valid;
    logic [31:0] c_out_instr;
    logic [31:0] c_out_imm;
    logic [2:0]  c_out_fmt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .ENABLE_CSR(1)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_instr(a_out_instr), .out_imm(a_out_imm), .out_fmt(a_out_fmt)
    );

    imm_decode_stage #(.XLEN(64), .ENABLE_CSR(1)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_instr(b_out_instr), .out_imm(b_out_imm), .out_fmt(b_out_fmt)
    );

    imm_decode_stage #(.XLEN(32), .ENABLE_CSR(0)) dut32n (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(c_in_ready), .in_instr(in_instr),
        .out_valid(c_out_valid), .out_ready(out_ready),
        .out_instr(c_out_instr), .out_imm(c_out_imm), .out_fmt(c_out_fmt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h00a10093;
        out_ready = 1'b1;
        tick();
        tick();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid got %0b exp 0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_in_ready got %0b exp 0", a_in_ready); end
        checks++; if (a_out_instr !== 32'h0) begin errors++; $display("[TB] FAIL rst_out_instr got %h exp 0", a_out_instr); end
        checks++; if (a_out_imm !== 32'h0) begin errors++; $display("[TB] FAIL rst_out_imm got %h exp 0", a_out_imm); end
        checks++; if (a_out_fmt !== 3'd0) begin errors++; $display("[TB] FAIL rst_out_fmt got %0d exp 0", a_out_fmt); end
        checks++; if (b_out_imm !== 64'h0) begin errors++; $display("[TB] FAIL rst_out_imm64 got %h exp 0", b_out_imm); end
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_in_ready got %0b exp 1", a_in_ready); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_release_out_valid got %0b exp 0", a_out_valid); end
    endtask

    task automatic test_decode();
        logic [31:0] vin   [12];
        logic [63:0] vimm  [12];
        logic [2:0]  vf32  [12];
        logic [2:0]  vf64  [12];
        logic [31:0] vimmn [12];
        logic [2:0]  vfn   [12];
        vin[0]  = 32'h00a10093; vimm[0]  = 64'h000000000000000A; vf32[0]  = 3'd1; vf64[0]  = 3'd1; vimmn[0]  = 32'h0000000A; vfn[0]  = 3'd1;
        vin[1]  = 32'hfe322c23; vimm[1]  = 64'hFFFFFFFFFFFFFFF8; vf32[1]  = 3'd2; vf64[1]  = 3'd2; vimmn[1]  = 32'hFFFFFFF8; vfn[1]  = 3'd2;
        vin[2]  = 32'hfe208ee3; vimm[2]  = 64'hFFFFFFFFFFFFFFFC; vf32[2]  = 3'd3; vf64[2]  = 3'd3; vimmn[2]  = 32'hFFFFFFFC; vfn[2]  = 3'd3;
        vin[3]  = 32'h123452b7; vimm[3]  = 64'h0000000012345000; vf32[3]  = 3'd4; vf64[3]  = 3'd4; vimmn[3]  = 32'h12345000; vfn[3]  = 3'd4;
        vin[4]  = 32'hff9ff0ef; vimm[4]  = 64'hFFFFFFFFFFFFFFF8; vf32[4]  = 3'd5; vf64[4]  = 3'd5; vimmn[4]  = 32'hFFFFFFF8; vfn[4]  = 3'd5;
        vin[5]  = 32'h0000001B; vimm[5]  = 64'h0000000000000000; vf32[5]  = 3'd7; vf64[5]  = 3'd1; vimmn[5]  = 32'h00000000; vfn[5]  = 3'd7;
        vin[6]  = 32'h3002D073; vimm[6]  = 64'h0000000000000005; vf32[6]  = 3'd6; vf64[6]  = 3'd6; vimmn[6]  = 32'h00000300; vfn[6]  = 3'd1;
        vin[7]  = 32'h002081b3; vimm[7]  = 64'h0000000000000000; vf32[7]  = 3'd0; vf64[7]  = 3'd0; vimmn[7]  = 32'h00000000; vfn[7]  = 3'd0;
        vin[8]  = 32'h0000003B; vimm[8]  = 64'h0000000000000000; vf32[8]  = 3'd7; vf64[8]  = 3'd0; vimmn[8]  = 32'h00000000; vfn[8]  = 3'd7;
        vin[9]  = 32'hffffffff; vimm[9]  = 64'h0000000000000000; vf32[9]  = 3'd7; vf64[9]  = 3'd7; vimmn[9]  = 32'h00000000; vfn[9]  = 3'd7;
        vin[10] = 32'h800000b7; vimm[10] = 64'hFFFFFFFF80000000; vf32[10] = 3'd4; vf64[10] = 3'd4; vimmn[10] = 32'h80000000; vfn[10] = 3'd4;
        vin[11] = 32'hfff00013; vimm[11] = 64'hFFFFFFFFFFFFFFFF; vf32[11] = 3'd1; vf64[11] = 3'd1; vimmn[11] = 32'hFFFFFFFF; vfn[11] = 3'd1;
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            in_valid = 1'b1;
            in_instr = vin[k];
            tick();
            in_valid = 1'b0;
            checks++; if (a_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL dec%0d_valid32 got %0b exp 1", k, a_out_valid); end
            checks++; if (a_out_instr !== vin[k]) begin errors++; $display("[TB] FAIL dec%0d_instr32 got %h exp %h", k, a_out_instr, vin[k]); end
            checks++; if (a_out_imm !== vimm[k][31:0]) begin errors++; $display("[TB] FAIL dec%0d_imm32 got %h exp %h", k, a_out_imm, vimm[k][31:0]); end
            checks++; if (a_out_fmt !== vf32[k]) begin errors++; $display("[TB] FAIL dec%0d_fmt32 got %0d exp %0d", k, a_out_fmt, vf32[k]); end
            checks++; if (b_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL dec%0d_valid64 got %0b exp 1", k, b_out_valid); end
            checks++; if (b_out_imm !== vimm[k]) begin errors++; $display("[TB] FAIL dec%0d_imm64 got %h exp %h", k, b_out_imm, vimm[k]); end
            checks++; if (b_out_fmt !== vf64[k]) begin errors++; $display("[TB] FAIL dec%0d_fmt64 got %0d exp %0d", k, b_out_fmt, vf64[k]); end
            checks++; if (c_out_imm !== vimmn[k]) begin errors++; $display("[TB] FAIL dec%0d_imm_nocsr got %h exp %h", k, c_out_imm, vimmn[k]); end
            checks++; if (c_out_fmt !== vfn[k]) begin errors++; $display("[TB] FAIL dec%0d_fmt_nocsr got %0d exp %0d", k, c_out_fmt, vfn[k]); end
        end
        tick();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL dec_drain_valid got %0b exp 0", a_out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h00100093;
        tick();
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_first_valid got %0b exp 1", a_out_valid); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_first_ready got %0b exp 1", a_in_ready); end
        in_instr = 32'h00200113;
        tick();
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_full_ready got %0b exp 0", a_in_ready); end
        checks++; if (a_out_instr !== 32'h00100093) begin errors++; $display("[TB] FAIL bp_hold_instr got %h exp 00100093", a_out_instr); end
        in_instr = 32'h00300193;
        tick();
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_stall_ready got %0b exp 0", a_in_ready); end
        checks++; if (a_out_instr !== 32'h00100093) begin errors++; $display("[TB] FAIL bp_stall_instr got %h exp 00100093", a_out_instr); end
        checks++; if (a_out_imm !== 32'h1) begin errors++; $display("[TB] FAIL bp_stall_imm got %h exp 00000001", a_out_imm); end
        out_ready = 1'b1;
        tick();
        checks++; if (a_out_instr !== 32'h00200113) begin errors++; $display("[TB] FAIL bp_second_instr got %h exp 00200113", a_out_instr); end
        checks++; if (a_out_imm !== 32'h2) begin errors++; $display("[TB] FAIL bp_second_imm got %h exp 00000002", a_out_imm); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_reopen_ready got %0b exp 1", a_in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_third_valid got %0b exp 1", a_out_valid); end
        checks++; if (a_out_instr !== 32'h00300193) begin errors++; $display("[TB] FAIL bp_third_instr got %h exp 00300193", a_out_instr); end
        checks++; if (a_out_imm !== 32'h3) begin errors++; $display("[TB] FAIL bp_third_imm got %h exp 00000003", a_out_imm); end
        tick();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_empty_valid got %0b exp 0", a_out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h00400213;
        tick();
        in_instr = 32'h00500293;
        tick();
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL fl_full_ready got %0b exp 0", a_in_ready); end
        flush = 1'b1;
        out_ready = 1'b1;
        in_instr = 32'h00600313;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL fl_full_valid got %0b exp 0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL fl_full_ready_after got %0b exp 1", a_in_ready); end
        tick();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL fl_no_stale got %0b exp 0", a_out_valid); end
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h00700393;
        tick();
        flush = 1'b1;
        in_instr = 32'h00800413;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL fl_accept_discard got %0b exp 0", a_out_valid); end
        tick();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL fl_accept_never got %0b exp 0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL fl_idle_ready got %0b exp 1", a_in_ready); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h00900493;
        tick();
        in_instr = 32'h00a00513;
        tick();
        rst = 1'b1;
        tick();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_valid got %0b exp 0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_ready got %0b exp 0", a_in_ready); end
        checks++; if (a_out_instr !== 32'h0) begin errors++; $display("[TB] FAIL mid_rst_instr got %h exp 0", a_out_instr); end
        checks++; if (a_out_imm !== 32'h0) begin errors++; $display("[TB] FAIL mid_rst_imm got %h exp 0", a_out_imm); end
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_release_ready got %0b exp 1", a_in_ready); end
        out_ready = 1'b1;
        tick();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_stale got %0b exp 0", a_out_valid); end
        in_valid = 1'b1;
        in_instr = 32'h00b00593;
        tick();
        in_valid = 1'b0;
        checks++; if (a_out_instr !== 32'h00b00593) begin errors++; $display("[TB] FAIL mid_resume_instr got %h exp 00b00593", a_out_instr); end
        checks++; if (a_out_imm !== 32'hB) begin errors++; $display("[TB] FAIL mid_resume_imm got %h exp 0000000b", a_out_imm); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
